// File: rtl/sram_fifo_ctrl.sv
// FIFO controller wrapping a single-port synchronous RAM. One grant per request,
// followed by a one-cycle completion hint; simultaneous requests alternate.
module sram_fifo_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              sram_write,
  input  logic              sram_read,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              sram_hint,
  output logic              sram_full,
  output logic              sram_empty,
  output logic [ADDR_W:0]   sram_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic              OP_WR    = 1'b0;
  localparam logic              OP_RD    = 1'b1;

  typedef enum logic {IDLE, HINT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              last_op_q, last_op_d;
  logic [DATA_W-1:0] data_out_q;
  logic              wr_ok, rd_ok, wr_gnt, rd_gnt;

  logic [DATA_W-1:0] mem [DEPTH];

  assign sram_full  = (count_q == CNT_FULL);
  assign sram_empty = (count_q == '0);
  assign sram_count = count_q;
  assign sram_hint  = (state_q == HINT);
  assign data_out   = data_out_q;

  assign wr_ok = sram_write && !sram_full;
  assign rd_ok = sram_read && !sram_empty;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_op_d = last_op_q;
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          // On a collision the type not granted last time wins.
          if (wr_ok && rd_ok) begin
            rd_gnt = (last_op_q == OP_WR);
            wr_gnt = (last_op_q == OP_RD);
          end else begin
            wr_gnt = wr_ok;
            rd_gnt = rd_ok;
          end
          if (wr_gnt) begin
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            count_d   = count_q + CNT_ONE;
            last_op_d = OP_WR;
            state_d   = HINT;
          end else if (rd_gnt) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            count_d   = count_q - CNT_ONE;
            last_op_d = OP_RD;
            state_d   = HINT;
          end
        end
      end
      HINT: begin
        // Requests are ignored here; a flush lands as the hint retires.
        state_d = IDLE;
        if (flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_op_q  <= OP_WR;
      data_out_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_op_q <= last_op_d;
      if (rd_gnt) data_out_q <= mem[rd_ptr_q];
    end
  end

  // RAM array has no reset; reset and flush only make old words unreachable.
  always_ff @(posedge clk) begin
    if (reset_n && wr_gnt) mem[wr_ptr_q] <= data_in;
  end

endmodule
